exe_result_pipe: RTL

//  Parametrised in-flight result pipeline between EXE and WB. Tracks DEPTH younger-to-older stages.

---
 rtl/exe_result_pipe_if.sv | 53 +++++
 rtl/exe_result_pipe.sv | 133 +++++++++++++
 2 files changed

// File: rtl/exe_result_pipe_if.sv
// exe_result_pipe_if: bus between EXE issue logic and the in-flight result pipe.
//   slave  (pipe side): issue request, late fill, flush, lookup addresses in;
//                       in_ready, forwarding results, stage view, WB retire out.
//   master (EXE side):  the mirror image.
// Lookup port k uses src_addr[5k+4:5k] / fwd_data[XLEN*k +: XLEN].
interface exe_result_pipe_if #(
  parameter int DEPTH   = 3,
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int OPW     = 2
);
  localparam int IW = $clog2(DEPTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         in_pc;
  logic [31:0]             in_inst;
  logic [4:0]              in_rd;
  logic                    in_regwrite;
  logic [OPW-1:0]          in_op;
  logic [XLEN-1:0]         in_data;
  logic                    in_dv;
  logic                    fill_en;
  logic [IW-1:0]           fill_idx;
  logic [XLEN-1:0]         fill_data;
  logic [DEPTH-1:0]        flush_mask;
  logic [NUM_SRC*5-1:0]    src_addr;
  logic [NUM_SRC-1:0]      fwd_hit;
  logic [NUM_SRC*XLEN-1:0] fwd_data;
  logic [NUM_SRC-1:0]      fwd_stall;
  logic [DEPTH-1:0]        stage_valid;
  logic [DEPTH*5-1:0]      stage_rd;
  logic                    wb_valid;
  logic [XLEN-1:0]         wb_pc;
  logic [31:0]             wb_inst;
  logic [XLEN-1:0]         wb_data;
  logic [4:0]              wb_rd;
  logic                    wb_regwrite;

  modport slave (
    input  in_valid, in_pc, in_inst, in_rd, in_regwrite, in_op, in_data, in_dv,
           fill_en, fill_idx, fill_data, flush_mask, src_addr,
    output in_ready, fwd_hit, fwd_data, fwd_stall, stage_valid, stage_rd,
           wb_valid, wb_pc, wb_inst, wb_data, wb_rd, wb_regwrite
  );

  modport master (
    output in_valid, in_pc, in_inst, in_rd, in_regwrite, in_op, in_data, in_dv,
           fill_en, fill_idx, fill_data, flush_mask, src_addr,
    input  in_ready, fwd_hit, fwd_data, fwd_stall, stage_valid, stage_rd,
           wb_valid, wb_pc, wb_inst, wb_data, wb_rd, wb_regwrite
  );
endinterface

// File: rtl/exe_result_pipe.sv
// exe_result_pipe: DEPTH-stage in-flight result pipe between EXE and WB.
//   Stage 0 is youngest, stage DEPTH-1 retires to WB. Each stage carries
//   pc/inst/rd/regwrite/op/result plus a data-valid bit; multi-cycle ops
//   issue with dv=0 and get their result through the fill port.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   io           exe_result_pipe_if.slave (issue, fill, flush, lookup, WB)
//   perf_*_o     retire / stall cycle counters (EXE_PIPE_PERF_EN only)
// Optional feature: define EXE_PIPE_PERF_EN to add perf_retired_o and
//   perf_stall_o (32-bit wrapping counters); absent in the default build.
module exe_result_pipe #(
  parameter int DEPTH   = 3,
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int OPW     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef EXE_PIPE_PERF_EN
  output logic [31:0] perf_retired_o,
  output logic [31:0] perf_stall_o,
`endif
  exe_result_pipe_if.slave io
);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic            v;
    logic            dv;
    logic            rw;
    logic [4:0]      rd;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t [DEPTH-1:0] stg_q, stg_d, stg_m;
  logic             stall;
  logic             wb_valid;

  // Oldest entry has no result yet: freeze the whole pipe.
  assign stall       = stg_q[DEPTH-1].v & ~stg_q[DEPTH-1].dv;
  assign io.in_ready = ~stall;

  // Fill and flush act on the pre-shift stage index; flush wins over fill.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stg_m[i] = stg_q[i];
      if (io.fill_en && io.fill_idx == IW'(i) && stg_q[i].v) begin
        stg_m[i].data = io.fill_data;
        stg_m[i].dv   = 1'b1;
      end
      if (io.flush_mask[i]) stg_m[i].v = 1'b0;
    end
  end

  // Shift when not stalled; the incoming issue bypasses the flush mask.
  always_comb begin
    stg_d = stg_m;
    if (!stall) begin
      for (int i = DEPTH - 1; i > 0; i--) stg_d[i] = stg_m[i-1];
      stg_d[0].v    = io.in_valid;
      stg_d[0].dv   = io.in_dv;
      stg_d[0].rw   = io.in_regwrite;
      stg_d[0].rd   = io.in_rd;
      stg_d[0].op   = io.in_op;
      stg_d[0].pc   = io.in_pc;
      stg_d[0].inst = io.in_inst;
      stg_d[0].data = io.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg_q <= '0;
    else        stg_q <= stg_d;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign io.stage_valid[i]      = stg_q[i].v;
    assign io.stage_rd[5*i +: 5]  = stg_q[i].rd;
  end

  assign wb_valid       = stg_q[DEPTH-1].v & stg_q[DEPTH-1].dv;
  assign io.wb_valid    = wb_valid;
  assign io.wb_pc       = stg_q[DEPTH-1].pc;
  assign io.wb_inst     = stg_q[DEPTH-1].inst;
  assign io.wb_data     = stg_q[DEPTH-1].data;
  assign io.wb_rd       = stg_q[DEPTH-1].rd;
  assign io.wb_regwrite = stg_q[DEPTH-1].rw;

  // Forwarding from registered state only. Scanning oldest->youngest and
  // overwriting leaves the youngest matching producer as the winner.
  logic [NUM_SRC-1:0]           hit_w, stl_w;
  logic [NUM_SRC-1:0][XLEN-1:0] fwd_w;

  always_comb begin
    hit_w = '0;
    stl_w = '0;
    fwd_w = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (stg_q[i].v && stg_q[i].rw && io.src_addr[5*k +: 5] != 5'd0 &&
            stg_q[i].rd == io.src_addr[5*k +: 5]) begin
          hit_w[k] = stg_q[i].dv;
          stl_w[k] = ~stg_q[i].dv;
          fwd_w[k] = stg_q[i].dv ? stg_q[i].data : '0;
        end
      end
    end
  end

  assign io.fwd_hit   = hit_w;
  assign io.fwd_stall = stl_w;
  assign io.fwd_data  = fwd_w;

`ifdef EXE_PIPE_PERF_EN
  logic [31:0] ret_cnt_q, stl_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      ret_cnt_q <= ret_cnt_q + {31'd0, wb_valid};
      stl_cnt_q <= stl_cnt_q + {31'd0, stall};
    end
  end

  assign perf_retired_o = ret_cnt_q;
  assign perf_stall_o   = stl_cnt_q;
`endif
endmodule
